// File: rtl/frame_ecc_pkg.sv
// -----------------------------------------------------------------------------
// frame_ecc_pkg
// Shared types for the frame-ECC error logger. It defines:
//   - ecc_class_t : how a readback result was classified.
//   - ecc_rec_t   : the 51-bit error record that is queued for the consumer.
// It also holds the widths of the individual record fields.
// -----------------------------------------------------------------------------
package frame_ecc_pkg;

    localparam int FAR_W  = 24;
    localparam int WORD_W = 7;
    localparam int BIT_W  = 5;
    localparam int SYND_W = 13;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2,
        CRC    = 2'd3
    } ecc_class_t;

    // 'class' and 'bit' are reserved words, so the fields are named cls/bitn.
    typedef struct packed {
        ecc_class_t          cls;
        logic [FAR_W-1:0]    far;
        logic [WORD_W-1:0]   word;
        logic [BIT_W-1:0]    bitn;
        logic [SYND_W-1:0]   synd;
    } ecc_rec_t;

endpackage

// File: rtl/frame_ecc_rec_fifo.sv
// -----------------------------------------------------------------------------
// frame_ecc_rec_fifo
// Synchronous first-word-fall-through FIFO that stores ecc_rec_t records.
// The head record sits in a register, so it can be read directly.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   wr_en_i       push request; it is accepted when the FIFO is not full,
//                 or when a pop happens in the same cycle
//   wr_data_i     record to push
//   rd_en_i       pop the head; it is ignored while the FIFO is empty
//   full_o        all FIFO_DEPTH entries are occupied
//   empty_o       no record is present (registered)
//   head_o        registered head record; it reads as zero while empty
// -----------------------------------------------------------------------------
module frame_ecc_rec_fifo
    import frame_ecc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en_i,
    input  ecc_rec_t wr_data_i,
    input  logic     rd_en_i,
    output logic     full_o,
    output logic     empty_o,
    output ecc_rec_t head_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ecc_rec_t    mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty_q, empty_d;
    ecc_rec_t    head_q, head_d;
    logic        push, pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = rd_en_i && !empty_q;
    assign push    = wr_en_i && (!full_o || pop);
    assign empty_o = empty_q;
    assign head_o  = head_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        head_d   = '0;
        // Compute the next head in advance. If the slot being written now
        // becomes the head, the RAM does not hold it yet, so the data is
        // bypassed from the write port.
        if (!empty_d) begin
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
                head_d = wr_data_i;
            else
                head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/frame_ecc_err_logger.sv
// -----------------------------------------------------------------------------
// frame_ecc_err_logger
// Registers the outputs of the frame-ECC readback primitive and classifies each
// readback result. Error records are queued in an FWFT FIFO, which is drained
// through a valid/ready port. The block also keeps saturating statistics
// counters and sticky status flags.
// Ports:
//   CLK, RST               clock and asynchronous active-high reset
//   CRCERROR, ECCERROR, ECCERRORSINGLE, SYNDROMEVALID, SYNDROME, FAR,
//   SYNWORD, SYNBIT        inputs from the ECC primitive
//   REC_VALID/REC_READY    record handshake
//   REC_*                  head record fields (registered)
//   CLR_STATS              clears the counters and the sticky flags
//   SCAN_CNT, SINGLE_CNT, MULTI_CNT  saturating event counters
//   CRC_STICKY, OVERFLOW   sticky status flags
// -----------------------------------------------------------------------------
module frame_ecc_err_logger #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CRCERROR,
    input  logic             ECCERROR,
    input  logic             ECCERRORSINGLE,
    input  logic             SYNDROMEVALID,
    input  logic [12:0]      SYNDROME,
    input  logic [23:0]      FAR,
    input  logic [6:0]       SYNWORD,
    input  logic [4:0]       SYNBIT,
    output logic             REC_VALID,
    input  logic             REC_READY,
    output logic [1:0]       REC_CLASS,
    output logic [23:0]      REC_FAR,
    output logic [6:0]       REC_WORD,
    output logic [4:0]       REC_BIT,
    output logic [12:0]      REC_SYND,
    input  logic             CLR_STATS,
    output logic [CNT_W-1:0] SCAN_CNT,
    output logic [CNT_W-1:0] SINGLE_CNT,
    output logic [CNT_W-1:0] MULTI_CNT,
    output logic             CRC_STICKY,
    output logic             OVERFLOW
);
    import frame_ecc_pkg::*;

    typedef enum logic {IDLE, PEND_CRC} arb_state_t;

    // Stage 1: input registers.
    logic              crc_q, ecc_q, single_q, sv_q;
    logic [SYND_W-1:0] synd_q;
    logic [FAR_W-1:0]  far_q;
    logic [WORD_W-1:0] word_q;
    logic [BIT_W-1:0]  bit_q;
    // Stage 2: previous values, used for edge detection.
    logic              sv_prev_q, crc_prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_q      <= 1'b0;
            ecc_q      <= 1'b0;
            single_q   <= 1'b0;
            sv_q       <= 1'b0;
            synd_q     <= '0;
            far_q      <= '0;
            word_q     <= '0;
            bit_q      <= '0;
            sv_prev_q  <= 1'b0;
            crc_prev_q <= 1'b0;
        end else begin
            crc_q      <= CRCERROR;
            ecc_q      <= ECCERROR;
            single_q   <= ECCERRORSINGLE;
            sv_q       <= SYNDROMEVALID;
            synd_q     <= SYNDROME;
            far_q      <= FAR;
            word_q     <= SYNWORD;
            bit_q      <= SYNBIT;
            sv_prev_q  <= sv_q;
            crc_prev_q <= crc_q;
        end
    end

    logic     syn_ev, crc_ev, syn_wr;
    ecc_rec_t syn_rec, crc_rec;

    assign syn_ev = sv_q && !sv_prev_q;
    assign crc_ev = crc_q && !crc_prev_q;
    // Clean results (class NONE) are counted but never queued.
    assign syn_wr = syn_ev && ecc_q;

    assign syn_rec = '{cls: (single_q ? SINGLE : MULTI), far: far_q,
                       word: word_q, bitn: bit_q, synd: synd_q};
    assign crc_rec = '{cls: CRC, far: far_q, word: '0, bitn: '0, synd: '0};

    // Write arbiter. Syndrome records take priority, and a CRC record is
    // parked in pend_q until the write port is free.
    arb_state_t state_q, state_d;
    ecc_rec_t   pend_q, pend_d;
    logic       wr_en;
    ecc_rec_t   wr_data;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wr_en   = 1'b0;
        wr_data = '0;
        unique case (state_q)
            IDLE: begin
                if (syn_wr) begin
                    wr_en   = 1'b1;
                    wr_data = syn_rec;
                    if (crc_ev) begin
                        pend_d  = crc_rec;
                        state_d = PEND_CRC;
                    end
                end else if (crc_ev) begin
                    wr_en   = 1'b1;
                    wr_data = crc_rec;
                end
            end
            PEND_CRC: begin
                // A further CRC edge while a record is pending is merged
                // into that record, so no second CRC record is queued.
                if (syn_wr) begin
                    wr_en   = 1'b1;
                    wr_data = syn_rec;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = pend_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    logic     fifo_full, fifo_empty, rd_fire;
    ecc_rec_t head;

    assign REC_VALID = !fifo_empty;
    assign rd_fire   = REC_VALID && REC_READY;

    frame_ecc_rec_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (REC_READY),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head)
    );

    assign REC_CLASS = head.cls;
    assign REC_FAR   = head.far;
    assign REC_WORD  = head.word;
    assign REC_BIT   = head.bitn;
    assign REC_SYND  = head.synd;

    // Statistics counters. CLR_STATS takes priority over any event in the
    // same cycle.
    logic [CNT_W-1:0] scan_q, single_cnt_q, multi_cnt_q;
    logic             crc_sticky_q, ovf_q;
    logic             drop;

    assign drop = wr_en && fifo_full && !rd_fire;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_q       <= '0;
            single_cnt_q <= '0;
            multi_cnt_q  <= '0;
            crc_sticky_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (CLR_STATS) begin
            scan_q       <= '0;
            single_cnt_q <= '0;
            multi_cnt_q  <= '0;
            crc_sticky_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (syn_ev && !ecc_q && !(&scan_q))
                scan_q <= scan_q + 1'b1;
            if (syn_wr && single_q && !(&single_cnt_q))
                single_cnt_q <= single_cnt_q + 1'b1;
            if (syn_wr && !single_q && !(&multi_cnt_q))
                multi_cnt_q <= multi_cnt_q + 1'b1;
            if (crc_ev)
                crc_sticky_q <= 1'b1;
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    assign SCAN_CNT   = scan_q;
    assign SINGLE_CNT = single_cnt_q;
    assign MULTI_CNT  = multi_cnt_q;
    assign CRC_STICKY = crc_sticky_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_frame_ecc_err_logger.sv
// -----------------------------------------------------------------------------
// tb_frame_ecc_err_logger
// Directed bench for frame_ecc_err_logger, built with FIFO_DEPTH=8 and
// CNT_W=4. Inputs are driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_ecc_err_logger;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CRCERROR, ECCERROR, ECCERRORSINGLE, SYNDROMEVALID;
    logic [12:0]   SYNDROME;
    logic [23:0]   FAR;
    logic [6:0]    SYNWORD;
    logic [4:0]    SYNBIT;
    logic          REC_VALID, REC_READY;
    logic [1:0]    REC_CLASS;
    logic [23:0]   REC_FAR;
    logic [6:0]    REC_WORD;
    logic [4:0]    REC_BIT;
    logic [12:0]   REC_SYND;
    logic          CLR_STATS;
    logic [CW-1:0] SCAN_CNT, SINGLE_CNT, MULTI_CNT;
    logic          CRC_STICKY, OVERFLOW;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    frame_ecc_err_logger #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .CRCERROR(CRCERROR), .ECCERROR(ECCERROR),
        .ECCERRORSINGLE(ECCERRORSINGLE), .SYNDROMEVALID(SYNDROMEVALID),
        .SYNDROME(SYNDROME), .FAR(FAR), .SYNWORD(SYNWORD), .SYNBIT(SYNBIT),
        .REC_VALID(REC_VALID), .REC_READY(REC_READY), .REC_CLASS(REC_CLASS),
        .REC_FAR(REC_FAR), .REC_WORD(REC_WORD), .REC_BIT(REC_BIT),
        .REC_SYND(REC_SYND), .CLR_STATS(CLR_STATS),
        .SCAN_CNT(SCAN_CNT), .SINGLE_CNT(SINGLE_CNT), .MULTI_CNT(MULTI_CNT),
        .CRC_STICKY(CRC_STICKY), .OVERFLOW(OVERFLOW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clr_inputs();
        SYNDROMEVALID  = 1'b0;
        ECCERROR       = 1'b0;
        ECCERRORSINGLE = 1'b0;
        CRCERROR       = 1'b0;
    endtask

    // Drives a one-cycle SYNDROMEVALID pulse. The task returns on the falling
    // edge after the edge where the event takes effect.
    task automatic syn_pulse(input logic single, input logic [23:0] f,
                             input logic [6:0] w, input logic [4:0] b,
                             input logic [12:0] s);
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b1; ECCERRORSINGLE = single;
        FAR = f; SYNWORD = w; SYNBIT = b; SYNDROME = s;
        nclk(1);
        clr_inputs();
        nclk(1);
    endtask

    initial begin
        RST = 1'b1; REC_READY = 1'b0; CLR_STATS = 1'b0;
        clr_inputs();
        SYNDROME = '0; FAR = '0; SYNWORD = '0; SYNBIT = '0;
        nclk(2);
        // Reset state
        chk("rst_valid",  REC_VALID,  0);
        chk("rst_class",  REC_CLASS,  0);
        chk("rst_far",    REC_FAR,    0);
        chk("rst_scan",   SCAN_CNT,   0);
        chk("rst_single", SINGLE_CNT, 0);
        chk("rst_multi",  MULTI_CNT,  0);
        chk("rst_crc",    CRC_STICKY, 0);
        chk("rst_ovf",    OVERFLOW,   0);
        RST = 1'b0;
        nclk(1);

        // One SINGLE event, with the 2-cycle latency to REC_VALID
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b1; ECCERRORSINGLE = 1'b1;
        FAR = 24'h012345; SYNWORD = 7'd17; SYNBIT = 5'd9; SYNDROME = 13'h0A5;
        nclk(1);
        chk("t1_valid_lat1", REC_VALID, 0);
        clr_inputs();
        nclk(1);
        chk("t1_valid",  REC_VALID,  1);
        chk("t1_class",  REC_CLASS,  1);
        chk("t1_far",    REC_FAR,    32'h012345);
        chk("t1_word",   REC_WORD,   17);
        chk("t1_bit",    REC_BIT,    9);
        chk("t1_synd",   REC_SYND,   32'h0A5);
        chk("t1_single", SINGLE_CNT, 1);
        nclk(1);
        chk("t1_stable", REC_FAR,    32'h012345);
        REC_READY = 1'b1;
        nclk(1);
        REC_READY = 1'b0;
        chk("t1_popped", REC_VALID, 0);

        // SYNDROMEVALID held high with a clean result
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nclk(1);
            chk("t2_novalid", REC_VALID, 0);
        end
        clr_inputs();
        nclk(2);
        chk("t2_scan",  SCAN_CNT, 1);
        chk("t2_valid", REC_VALID, 0);

        // MULTI event and CRC edge in the same cycle
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b1; ECCERRORSINGLE = 1'b0; CRCERROR = 1'b1;
        FAR = 24'hABCDEF; SYNWORD = 7'd3; SYNBIT = 5'd4; SYNDROME = 13'h1FF;
        nclk(1);
        clr_inputs();
        nclk(1);
        chk("t3_valid0", REC_VALID,  1);
        chk("t3_class0", REC_CLASS,  2);
        chk("t3_far0",   REC_FAR,    32'hABCDEF);
        chk("t3_word0",  REC_WORD,   3);
        chk("t3_multi",  MULTI_CNT,  1);
        chk("t3_crc",    CRC_STICKY, 1);
        REC_READY = 1'b1;
        nclk(1);
        chk("t3_valid1", REC_VALID, 1);
        chk("t3_class1", REC_CLASS, 3);
        chk("t3_far1",   REC_FAR,   32'hABCDEF);
        chk("t3_word1",  REC_WORD,  0);
        chk("t3_bit1",   REC_BIT,   0);
        chk("t3_synd1",  REC_SYND,  0);
        nclk(1);
        REC_READY = 1'b0;
        chk("t3_empty", REC_VALID, 0);

        // Clear the stats, then overflow the FIFO with 10 SINGLE events
        CLR_STATS = 1'b1;
        nclk(1);
        CLR_STATS = 1'b0;
        chk("clr_crc",   CRC_STICKY, 0);
        chk("clr_multi", MULTI_CNT,  0);
        chk("clr_scan",  SCAN_CNT,   0);
        for (int i = 0; i < 10; i++)
            syn_pulse(1'b1, 24'h000100 + 24'(i), 7'(i), 5'(i), 13'(i));
        chk("t4_ovf",    OVERFLOW,   1);
        chk("t4_single", SINGLE_CNT, 10);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_drain_valid", REC_VALID, 1);
            chk("t4_drain_far",   REC_FAR,   32'h100 + i);
            chk("t4_drain_word",  REC_WORD,  i);
            REC_READY = 1'b1;
            nclk(1);
        end
        REC_READY = 1'b0;
        chk("t4_empty", REC_VALID, 0);

        // Saturation of MULTI_CNT, then CLR_STATS together with an event
        CLR_STATS = 1'b1;
        nclk(1);
        CLR_STATS = 1'b0;
        for (int i = 0; i < 20; i++)
            syn_pulse(1'b0, 24'h000200 + 24'(i), 7'd1, 5'd1, 13'd1);
        chk("t5_sat", MULTI_CNT, 15);
        chk("t5_ovf", OVERFLOW,  1);
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b1; ECCERRORSINGLE = 1'b0;
        nclk(1);
        clr_inputs();
        CLR_STATS = 1'b1;
        nclk(1);
        CLR_STATS = 1'b0;
        chk("t5_clr_multi", MULTI_CNT, 0);
        chk("t5_clr_ovf",   OVERFLOW,  0);
        chk("t5_fifo_kept", REC_VALID, 1);
        chk("t5_head_far",  REC_FAR,   32'h200);
        REC_READY = 1'b1;
        nclk(10);
        REC_READY = 1'b0;
        chk("t5_drained", REC_VALID, 0);

        // Reset with 3 records queued and a CRC record pending
        syn_pulse(1'b1, 24'h000300, 7'd1, 5'd1, 13'd1);
        syn_pulse(1'b1, 24'h000301, 7'd2, 5'd2, 13'd2);
        SYNDROMEVALID = 1'b1; ECCERROR = 1'b1; ECCERRORSINGLE = 1'b0; CRCERROR = 1'b1;
        FAR = 24'h000302;
        nclk(1);
        clr_inputs();
        nclk(1);
        chk("t6_pre_valid", REC_VALID, 1);
        chk("t6_pre_far",   REC_FAR,   32'h300);
        chk("t6_pre_crc",   CRC_STICKY, 1);
        RST = 1'b1;
        #1;
        chk("t6_rst_valid",  REC_VALID,  0);
        chk("t6_rst_far",    REC_FAR,    0);
        chk("t6_rst_class",  REC_CLASS,  0);
        chk("t6_rst_single", SINGLE_CNT, 0);
        chk("t6_rst_multi",  MULTI_CNT,  0);
        chk("t6_rst_crc",    CRC_STICKY, 0);
        nclk(1);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nclk(1);
            chk("t6_no_stale", REC_VALID, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_ecc_err_logger.md
# frame_ecc_err_logger

Downstream consumer of the frame-ECC readback primitive. Samples that block's syndrome and CRC outputs, classifies each readback result, and queues the errors as records in a small first-word-fall-through FIFO. Software or the correction engine drains the FIFO through a valid/ready port. Also keeps saturating statistics counters and sticky status flags for the configuration-scrub controller.

## Interface
Parameters:
- FIFO_DEPTH, 8: record FIFO entries; power of two, 2..64.
- CNT_W, 16: width of each statistics counter.

Ports:
- CLK  in  1  sole clock; all inputs synchronous to it.
- RST  in  1  asynchronous, active-high reset.
- CRCERROR  in  1  CRC error level from the ECC primitive.
- ECCERROR  in  1  ECC error present, qualified by SYNDROMEVALID.
- ECCERRORSINGLE  in  1  single-bit (correctable) error, qualified by SYNDROMEVALID.
- SYNDROMEVALID  in  1  syndrome-valid strobe; may stay high several cycles.
- SYNDROME  in  13  raw syndrome.
- FAR  in  24  frame address of the reported frame.
- SYNWORD  in  7  word index of the erroneous bit.
- SYNBIT  in  5  bit index within the word.
- REC_VALID  out  1  FIFO head holds a record.
- REC_READY  in  1  consumer accepts the head record.
- REC_CLASS  out  2  1=SINGLE, 2=MULTI, 3=CRC.
- REC_FAR  out  24  record frame address.
- REC_WORD  out  7  record word index.
- REC_BIT  out  5  record bit index.
- REC_SYND  out  13  record syndrome.
- CLR_STATS  in  1  clears counters and sticky flags.
- SCAN_CNT  out  CNT_W  clean frame results (class NONE).
- SINGLE_CNT  out  CNT_W  single-bit error events.
- MULTI_CNT  out  CNT_W  multi-bit error events.
- CRC_STICKY  out  1  a CRC error event has occurred.
- OVERFLOW  out  1  a record was dropped because the FIFO was full.

## Operation
- Stage 1: every input is registered at each CLK edge. Stage 2 holds the previous values of SYNDROMEVALID and CRCERROR for edge detection.
- Syndrome event: rising edge of registered SYNDROMEVALID. The event is classified from the stage-1 values:
  - ECCERROR=0: class NONE. SCAN_CNT increments; no record is written.
  - ECCERROR=1, ECCERRORSINGLE=1: class SINGLE. SINGLE_CNT increments; a record is written.
  - ECCERROR=1, ECCERRORSINGLE=0: class MULTI. MULTI_CNT increments; a record is written.
- CRC event: rising edge of registered CRCERROR. CRC_STICKY is set. A record is written with class CRC, the current FAR, and WORD, BIT and SYND all zero.
- Write arbiter, states IDLE and PEND_CRC:
  - A syndrome event and a CRC event in the same cycle: the syndrome record is written first. The CRC record is latched and the arbiter enters PEND_CRC.
  - PEND_CRC writes the CRC record on the next cycle, then returns to IDLE.
  - A new syndrome event arriving while in PEND_CRC is written first; the pending CRC record waits one more cycle.
  - A second CRC edge while a CRC record is pending is merged into the pending record; it is not queued twice.
- FIFO full on write: the record is dropped and OVERFLOW is set. Counters still increment.
- FIFO full with a read (REC_VALID & REC_READY) in the same cycle: the write is accepted.
- Counters saturate at all-ones.
- CLR_STATS clears all three counters, CRC_STICKY and OVERFLOW. It has priority over an event in the same cycle; that event is not counted. CLR_STATS does not flush the FIFO and does not affect record writes.
- Reset: FIFO empty, arbiter in IDLE, stage registers cleared. REC_VALID=0, all REC_* outputs 0, all counters 0, CRC_STICKY=0, OVERFLOW=0.
- Reset asserted mid-operation discards all queued and pending records immediately.

## Timing
- Input sampled at edge k; event detected in the cycle after edge k.
- FIFO write, counter update and sticky-flag set occur at edge k+1.
- REC_VALID rises after edge k+1 if the FIFO was empty: 2-cycle latency from input to record.
- A pending CRC record adds one cycle.
- First-word-fall-through:
  - REC_* outputs are stable while REC_VALID=1 and REC_READY=0.
  - The head pops at an edge where REC_VALID & REC_READY.
  - The next record appears in the following cycle.
- Back-to-back pops are supported at one record per cycle.
- The REC_* outputs are registered. No combinational path exists from REC_READY to REC_VALID.

## Structure
- Package frame_ecc_pkg contains:
  - enum ecc_class_t: NONE=0, SINGLE=1, MULTI=2, CRC=3.
  - packed struct ecc_rec_t {class, far, word, bit, synd}, 51 bits.
  - localparams for field widths: 24, 7, 5, 13.
- Sub-module frame_ecc_rec_fifo: generic synchronous FWFT FIFO over ecc_rec_t.
  - Outputs full, empty, and a registered head.
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit.
- Top level holds the input stage, edge detection, classifier, arbiter and counters.

## Test plan
- SYNDROMEVALID pulse with ECCERROR=1, ECCERRORSINGLE=1, FAR=0x012345, WORD=17, BIT=9, SYND=0x0A5 -> exactly one record {SINGLE, 0x012345, 17, 9, 0x0A5}; REC_VALID rises 2 cycles after sampling; SINGLE_CNT=1.
- SYNDROMEVALID held 5 cycles with ECCERROR=0 -> SCAN_CNT=1, no record, REC_VALID stays 0.
- CRCERROR and SYNDROMEVALID (MULTI) rise in the same cycle -> MULTI record then CRC record on consecutive cycles; MULTI_CNT=1; CRC_STICKY=1.
- 10 SINGLE events with REC_READY=0 and FIFO_DEPTH=8 -> 8 records retained in order, OVERFLOW=1, SINGLE_CNT=10; draining returns the first 8 records in order.
- CNT_W=4 with 20 MULTI events -> MULTI_CNT holds at 15. CLR_STATS coincident with a 21st event -> MULTI_CNT=0, OVERFLOW=0.
- RST asserted with 3 records queued and a CRC record pending -> REC_VALID=0 immediately, all outputs 0; after release, no stale record appears.
